// File: rtl/mul_seq_ctrl.sv
// Multi-cycle RV32M multiply sequencer: four 16x16 partial products summed into a 64-bit accumulator.
// Optional macro MUL_ZERO_BYPASS_EN: a zero operand skips straight from PP0 to DONE.

module mulNbits #(
   parameter int N = 16
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic [1:0]     signed_mode,
   output logic [2*N-1:0] product
);
   logic [2*N-1:0] a_ext;
   logic [2*N-1:0] b_ext;

   // Extending to 2N bits and truncating the product gives the exact signed/unsigned result.
   always_comb begin
      a_ext   = {{N{signed_mode[0] & a[N-1]}}, a};
      b_ext   = {{N{signed_mode[1] & b[N-1]}}, b};
      product = a_ext * b_ext;
   end
endmodule

module mul_seq_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int HALF = XLEN / 2;

   typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [XLEN-1:0]   a_reg;
   logic [XLEN-1:0]   b_reg;
   logic [1:0]        op_reg;
   logic              sign_a;
   logic              sign_b;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] pp_ext;
   logic [2*XLEN-1:0] addend;
   logic [2*XLEN-1:0] acc_sum;
   logic [HALF-1:0]   pp_a;
   logic [HALF-1:0]   pp_b;
   logic [1:0]        mode;
   logic [XLEN-1:0]   pp;
`ifdef MUL_ZERO_BYPASS_EN
   logic              operand_zero;

   assign operand_zero = (a_reg == '0) || (b_reg == '0);
`endif

   mulNbits #(.N(HALF)) u_mul (
      .a           (pp_a),
      .b           (pp_b),
      .signed_mode (mode),
      .product     (pp)
   );

   always_comb begin
      next_state = state;
      pp_a       = a_reg[HALF-1:0];
      pp_b       = b_reg[HALF-1:0];
      mode       = 2'b00;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) next_state = PP0;
         end
         PP0: begin
            busy_o = 1'b1;
            if (kill_i) next_state = IDLE;
`ifdef MUL_ZERO_BYPASS_EN
            else if (operand_zero) next_state = DONE;
`endif
            else next_state = PP1;
         end
         PP1: begin
            busy_o     = 1'b1;
            pp_b       = b_reg[XLEN-1:HALF];
            mode       = {sign_b, 1'b0};
            next_state = kill_i ? IDLE : PP2;
         end
         PP2: begin
            busy_o     = 1'b1;
            pp_a       = a_reg[XLEN-1:HALF];
            mode       = {1'b0, sign_a};
            next_state = kill_i ? IDLE : PP3;
         end
         PP3: begin
            busy_o     = 1'b1;
            pp_a       = a_reg[XLEN-1:HALF];
            pp_b       = b_reg[XLEN-1:HALF];
            mode       = {sign_b, sign_a};
            next_state = kill_i ? IDLE : DONE;
         end
         DONE: begin
            done_o     = 1'b1;
            next_state = start_i ? PP0 : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Signed steps sign-extend their partial product; the sum wraps modulo 2^64.
   always_comb begin
      pp_ext = (|mode) ? {{XLEN{pp[XLEN-1]}}, pp} : {{XLEN{1'b0}}, pp};
      case (state)
         PP0:      addend = pp_ext;
         PP1, PP2: addend = pp_ext << HALF;
         PP3:      addend = pp_ext << XLEN;
         default:  addend = '0;
      endcase
      acc_sum = acc + addend;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= 2'b00;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         acc      <= '0;
         result_o <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  a_reg  <= rs1_i;
                  b_reg  <= rs2_i;
                  op_reg <= op_i;
                  sign_a <= (op_i == 2'b01) || (op_i == 2'b10);
                  sign_b <= (op_i == 2'b01);
                  acc    <= '0;
               end
            end
            PP0: begin
`ifdef MUL_ZERO_BYPASS_EN
               if (!kill_i && operand_zero) begin
                  acc      <= '0;
                  result_o <= '0;
               end else begin
                  acc <= acc_sum;
               end
`else
               acc <= acc_sum;
`endif
            end
            PP1, PP2: acc <= acc_sum;
            PP3: begin
               acc <= acc_sum;
               if (!kill_i)
                  result_o <= (op_reg == 2'b00) ? acc_sum[XLEN-1:0] : acc_sum[2*XLEN-1:XLEN];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU).
- Reuses one instance of the existing mulNbits datapath, configured with N=16. Each 32x32 product is computed as four 16x16 partial products, one per cycle, summed into a 64-bit accumulator.
- Sits in the execute stage beside the ALU. It provides a start/busy/done handshake to the core pipeline and supports a kill input for pipeline flushes.

Parameters:
- XLEN, 32, operand width. Fixed at 32; the half-width is XLEN/2 = 16 and is passed to mulNbits as N.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request a new multiply; sampled only when idle.
- kill_i  input  1  abort an in-flight multiply (pipeline flush).
- op_i  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- rs1_i  input  32  operand A.
- rs2_i  input  32  operand B.
- busy_o  output  1  high while an operation is in flight.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  32  product low word (MUL) or high word (all others).

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy_o=0, done_o=0, result_o=0.
  - Accumulator, latched operands, latched op and sign flags all cleared.
  - Reset asserted mid-operation discards the operation; no done_o is produced.
- FSM states: IDLE, PP0, PP1, PP2, PP3, DONE.
- IDLE or DONE with start_i=1:
  - Latch rs1_i, rs2_i and op_i.
  - Set sign_a = 1 for op 01 and 10.
  - Set sign_b = 1 for op 01 only.
  - Clear the accumulator and go to PP0.
- start_i in any other state is ignored. The requester must hold its instruction until done_o.
- Partial-product steps (one per cycle). aL/aH and bL/bH are the low and high 16-bit halves of the latched operands:
  - PP0: aL*bL, both unsigned, added at bit 0, zero-extended.
  - PP1: aL*bH, signed_mode={sign_b,0}, added at bit 16.
  - PP2: aH*bL, signed_mode={0,sign_a}, added at bit 16.
  - PP3: aH*bH, signed_mode={sign_b,sign_a}, added at bit 32.
- Partial-product extension and wrap:
  - Each 32-bit mulNbits result is sign-extended to 64 bits if any signed_mode bit used in that step is 1; otherwise it is zero-extended.
  - Accumulation is modulo 2^64; wrap-around is intended.
- PP3 then DONE:
  - After PP3 the FSM goes to DONE.
  - In DONE: done_o=1 for exactly that cycle.
  - result_o = acc[31:0] for MUL, acc[63:32] otherwise. result_o is registered and held until the next DONE or reset.
  - DONE returns to IDLE unless start_i=1 (back-to-back start accepted).
- busy_o is 1 in PP0..PP3 and 0 in IDLE and DONE.
- Latency: start sampled at edge T, done_o high in cycle T+5. Throughput is one multiply per 5 cycles.
- kill_i:
  - In PP0..PP3, kill_i=1 returns the FSM to IDLE at the next edge.
  - done_o is not asserted and result_o keeps its previous value.
  - kill_i and start_i both high in IDLE: start wins.
  - kill_i in DONE has no effect; done_o is already being presented.
- Operand inputs are not used after the latch cycle; they may change freely while busy.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: if the latched rs1 or rs2 is zero, the FSM goes from PP0 directly to DONE with an accumulator of 0 and result_o=0. Latency becomes 2 cycles (start at T, done_o at T+2).
- Not defined: every operation takes the full 5-cycle sequence and no zero-detect logic is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- MUL, rs1=7, rs2=6 -> done_o exactly 5 cycles after start, result_o=0x0000002A, busy_o high for 4 cycles.
- MULHU, rs1=rs2=0xFFFFFFFF -> result_o=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- MULH, 0x80000000 x 0x80000000 -> 0x40000000; MULH, 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHSU, rs1=0x00000002, rs2=0x80000000 -> 0x00000001.
- Interruption cases:
  - kill_i in PP2 -> no done_o, returns to IDLE, result_o unchanged.
  - Async reset asserted in PP1 -> all outputs 0 immediately.
  - start_i pulsed while busy -> ignored, first result correct.
- Back-to-back start in DONE (MUL 3x5, then MUL 0x10000x0x10000) -> 0x0000000F then 0x00000000, 5 cycles apart.
- With MUL_ZERO_BYPASS_EN defined: MULH 0 x 0x12345678 -> result_o=0, done_o 2 cycles after start.
